// File: rtl/aes_subbytes_iter_pkg.sv
// Shared AES definitions: state geometry, SubBytes FSM encodings and the forward S-box.
// The S-box table is also the source for the key-expansion SubWord logic.
package aes_subbytes_iter_pkg;

  localparam int unsigned NUM_BYTES = 16;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned STATE_W   = NUM_BYTES * BYTE_W;
  localparam int unsigned ST_W      = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_SUB  = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

  // Column-major AES state viewed as 16 bytes; element i is state[8*i+7:8*i].
  typedef logic [NUM_BYTES-1:0][BYTE_W-1:0] aes_state_t;

  // Byte index of (row, col) in the column-major state: row + 4*col.
  function automatic logic [3:0] byte_idx(input logic [1:0] row, input logic [1:0] col);
    return {col, row};
  endfunction

  localparam logic [BYTE_W-1:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_subbytes_iter_sbox.sv
// Combinational forward AES S-box lookup, one byte in, one byte out.
module aes_sbox
  import aes_subbytes_iter_pkg::*;
(
  input  logic [BYTE_W-1:0] x,
  output logic [BYTE_W-1:0] y_c
);

  assign y_c = SBOX[x];

endmodule

// File: rtl/aes_subbytes_iter.sv
// Iterative AES SubBytes: substitutes LANES bytes per cycle through shared S-boxes,
// with valid/ready on both sides and a registered output state.
module aes_subbytes_iter
  import aes_subbytes_iter_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] state_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_out,
  output logic               busy
);

  localparam int unsigned NCYC     = NUM_BYTES / LANES;
  localparam int unsigned CNT_W    = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_chk
    $error("aes_subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  logic [ST_W-1:0]    state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  aes_state_t         blk_q, blk_d, blk_sub;
  logic [STATE_W-1:0] out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [3:0]         lane_base;
  logic [BYTE_W-1:0]  lane_in  [LANES];
  logic [BYTE_W-1:0]  lane_out [LANES];

  // Lane j works on byte LANES*cnt + j; lane groups never overlap.
  always_comb begin : p_lane_sel
    lane_base = 4'(LANES * 32'(cnt_q));
    for (int unsigned j = 0; j < LANES; j++) begin
      lane_in[j] = blk_q[lane_base + 4'(j)];
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    aes_sbox u_sbox (
      .x   (lane_in[j]),
      .y_c (lane_out[j])
    );
  end

  // Working state with the current lane group replaced in place.
  always_comb begin : p_lane_merge
    blk_sub = blk_q;
    for (int unsigned j = 0; j < LANES; j++) begin
      blk_sub[lane_base + 4'(j)] = lane_out[j];
    end
  end

  always_comb begin : p_fsm
    state_d     = state_q;
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          blk_d   = state_in;
          cnt_d   = '0;
          state_d = ST_SUB;
        end
      end
      ST_SUB: begin
        blk_d = blk_sub;
        if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          out_d       = blk_sub;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        // Ready passes straight through so a new block can load on the output handshake.
        in_ready = out_ready;
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            blk_d   = state_in;
            cnt_d   = '0;
            state_d = ST_SUB;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SUB);
  end

  always_ff @(posedge clk) begin : p_regs
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      blk_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign state_out = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule
